des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Iterative DES key scheduler; sits directly upstream of the round-function stage and drives its 48-bit key input.
- Latches a 64-bit DES key on start, applies PC-1, then emits the 16 round subkeys (PC-2 of C/D) one per accepted handshake.
- Encrypt order is K1..K16; decrypt order is K16..K1, generated by right-rotation, so no key storage is needed.
- Bit order matches the round function: index 0 = DES bit 1 (MSB-first).

Parameters:
- none; DES widths are fixed (key 64, C/D 28 each, subkey 48).

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new schedule; sampled only in IDLE
- decrypt  in  1  0 = encrypt order, 1 = decrypt order; latched with start
- key  in  [0:63]  DES key incl. parity bits 8,16,..,64; latched with start
- subkey  out  [0:47]  current round subkey, PC-2(C,D)
- round_idx  out  4  current emitted position, 0..15 (0 = first subkey delivered)
- subkey_valid  out  1  subkey/round_idx valid
- subkey_ready  in  1  downstream accepts subkey this cycle
- busy  out  1  schedule in progress (RUN state)
- done  out  1  one-cycle pulse after the 16th subkey is accepted
- parity_err  out  1  one-cycle pulse on rejected key (feature only; else constant 0)

Behaviour:
- Reset (async, rst=1): state=IDLE; C=D=0; round_idx=0; subkey_valid=0; busy=0; done=0; parity_err=0; latched decrypt=0. subkey=PC-2(0,0)=0.
- Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE:
  - start=1 -> next edge: load {C,D}=PC-1(key); latch decrypt.
  - Encrypt: C,D are additionally rotated left by S[1] in the same load.
  - Decrypt: no rotation at load, because C16=C0.
  - Then go to RUN with round_idx=0, subkey_valid=1, busy=1.
  - Latency start->first valid subkey = 1 cycle.
- RUN:
  - subkey is combinational PC-2 of the C/D registers and stays stable while subkey_valid=1 and subkey_ready=0.
  - On subkey_valid & subkey_ready with round_idx<15: round_idx+1, and C,D rotate once. Encrypt: rotate left by S[round_idx+2]. Decrypt: rotate right by S[16-round_idx].
  - On handshake with round_idx=15: go to DONE; subkey_valid=0; busy=0.
- DONE: done=1 for exactly one cycle; return to IDLE; round_idx=0. C/D are don't-care.
- start, key and decrypt are ignored outside IDLE. Changing them mid-run has no effect.
- start asserted in the DONE cycle is ignored. It is accepted on the following IDLE cycle if still high.
- subkey_ready while subkey_valid=0 has no effect.
- rst mid-run: immediate abort to reset values; no done pulse.
- Rotation is modulo 28 within C and within D independently; no bit crosses between the halves.

Optional Feature:
- Macro: DES_KS_PARITY_CHECK_EN.
- Enabled: on start in IDLE, each key byte must have odd parity. If any byte fails, stay in IDLE, pulse parity_err for 1 cycle, and assert no subkey_valid.
- Disabled: parity bits are ignored (PC-1 drops them), and parity_err is tied to 0.

Test Plan:
- Encrypt, key=133457799BBCDFF1, ready=1 -> first valid 1 cycle after start; idx0 subkey=1B02EFFC7072; idx15=CB3D8B0E17F5; done pulses 1 cycle after idx15 handshake; exactly 16 valid handshakes.
- Decrypt, same key -> idx0=CB3D8B0E17F5, idx15=1B02EFFC7072; the full sequence equals the encrypt sequence reversed.
- Backpressure: encrypt run, hold ready=0 for 5 cycles at idx3 -> subkey/round_idx unchanged and valid held for all 5 cycles; the sequence resumes intact.
- Mid-run start with a different key plus decrypt toggle -> ignored; the sequence still matches the original encrypt vectors.
- Assert rst at idx7 -> all outputs at reset values asynchronously, no done pulse; a new start yields idx0=1B02EFFC7072.
- With DES_KS_PARITY_CHECK_EN: key=0000000000000000 -> parity_err pulse, no valid; key=133457799BBCDFF1 -> normal run, parity_err=0.

Source files
------------

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on start, then one PC-2 subkey per handshake.
// Encrypt order K1..K16 by left rotation; decrypt order K16..K1 by right rotation.
// Optional build macro: DES_KS_PARITY_CHECK_EN rejects keys whose bytes lack odd parity.
module des_key_schedule (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        decrypt,
   input  logic [0:63] key,
   output logic [0:47] subkey,
   output logic [3:0]  round_idx,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic        busy,
   output logic        done,
   output logic        parity_err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Permutation tables, 0-based bit positions (0 = DES bit 1)
   localparam logic [5:0] PC1 [56] = '{
      56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
       9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
      62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
      13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3};
   localparam logic [5:0] PC2 [48] = '{
      13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
      22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
      40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
      43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31};

   state_t      state, state_next;
   logic [0:27] c, d;
   logic        dec_q;
   logic        key_ok;
   logic        accept;
   logic        last;
   logic        two;
   logic [0:55] cd_load;
   logic [0:27] c_load, d_load;

   function automatic logic [0:55] pc1_perm(input logic [0:63] k);
      logic [0:55] r;
      r = '0;
      for (int unsigned i = 0; i < 56; i++) r[i] = k[PC1[i]];
      return r;
   endfunction

   // Rotate a 28-bit half by one or two places; left means toward bit 0
   function automatic logic [0:27] rot28(input logic [0:27] x, input logic left, input logic dbl);
      if (left) return dbl ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
      else      return dbl ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
   endfunction

   // Schedule positions (1..16) that use a single-place shift
   function automatic logic single_shift(input logic [4:0] n);
      return (n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
   endfunction

`ifdef DES_KS_PARITY_CHECK_EN
   // Every key byte must carry odd parity
   always_comb begin
      key_ok = 1'b1;
      for (int unsigned i = 0; i < 8; i++)
         if (^key[8*i +: 8] == 1'b0) key_ok = 1'b0;
   end

   // One-cycle pulse when a start is refused for bad parity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_err <= 1'b0;
      else     parity_err <= (state == IDLE) && start && !key_ok;
   end
`else
   logic key_unused;
   assign key_ok     = 1'b1;
   assign parity_err = 1'b0;
   assign key_unused = ^key;
`endif

   assign accept  = (state == IDLE) && start && key_ok;
   assign last    = (round_idx == 4'd15);
   assign cd_load = pc1_perm(key);
   // Encrypt preloads the first left shift so K1 is ready one cycle after start
   assign c_load  = decrypt ? cd_load[0:27]  : rot28(cd_load[0:27], 1'b1, 1'b0);
   assign d_load  = decrypt ? cd_load[28:55] : rot28(cd_load[28:55], 1'b1, 1'b0);
   // Encrypt advances by S[idx+2]; decrypt undoes S[16-idx]
   assign two     = dec_q ? !single_shift(5'd16 - {1'b0, round_idx})
                          : !single_shift({1'b0, round_idx} + 5'd2);

   assign subkey_valid = (state == RUN);
   assign busy         = (state == RUN);
   assign done         = (state == DONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state: IDLE -> RUN on accepted start, RUN -> DONE on last handshake
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (subkey_ready && last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // C/D halves, round counter and latched direction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c         <= '0;
         d         <= '0;
         round_idx <= '0;
         dec_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               c         <= c_load;
               d         <= d_load;
               dec_q     <= decrypt;
               round_idx <= '0;
            end
            RUN: if (subkey_ready && !last) begin
               round_idx <= round_idx + 4'd1;
               c         <= rot28(c, !dec_q, two);
               d         <= rot28(d, !dec_q, two);
            end
            DONE:    round_idx <= '0;
            default: ;
         endcase
      end
   end

   // Subkey is PC-2 of the current C/D registers
   always_comb begin
      logic [0:55] cd;
      cd     = {c, d};
      subkey = '0;
      for (int unsigned i = 0; i < 48; i++) subkey[i] = cd[PC2[i]];
   end

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: the stimulus pushes the expected
// subkey sequence computed from cumulative shifts of C0/D0, a negedge monitor pops and compares.
module tb_des_key_schedule;

   logic        clk;
   logic        rst;
   logic        start;
   logic        decrypt;
   logic [0:63] key;
   logic [0:47] subkey;
   logic [3:0]  round_idx;
   logic        subkey_valid;
   logic        subkey_ready;
   logic        busy;
   logic        done;
   logic        parity_err;

   des_key_schedule dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .decrypt      (decrypt),
      .key          (key),
      .subkey       (subkey),
      .round_idx    (round_idx),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .busy         (busy),
      .done         (done),
      .parity_err   (parity_err)
   );

   // Standard DES tables, 1-based as published
   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
   localparam logic [63:0] OTHER_KEY = 64'h0E329232EA6D0D73;
   localparam logic [47:0] K1_KNOWN  = 48'h1B02EFFC7072;
   localparam logic [47:0] K16_KNOWN = 48'hCB3D8B0E17F5;

   typedef struct {
      logic [3:0]  idx;
      logic [0:47] sk;
   } exp_t;

   exp_t        sb [$];
   logic [0:47] got [16];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          ready_mode = 0;
   int          stall_cnt = 0;
   int          stalled_obs = 0;
   bit          done_due = 0;
   bit          perr_due = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Subkey for round r (1..16): C/D rotated left by the cumulative shift count
   function automatic logic [0:47] model_key(input logic [0:63] k, input int r);
      logic [0:27] c0, d0;
      logic [0:47] ks;
      int tot, p;
      tot = 0;
      for (int j = 0; j < r; j++) tot += SHIFTS[j];
      for (int j = 0; j < 28; j++) begin
         c0[j] = k[PC1_T[j] - 1];
         d0[j] = k[PC1_T[j + 28] - 1];
      end
      for (int i = 0; i < 48; i++) begin
         p = PC2_T[i] - 1;
         if (p < 28) ks[i] = c0[(p + tot) % 28];
         else        ks[i] = d0[(p - 28 + tot) % 28];
      end
      return ks;
   endfunction

   function automatic logic [0:63] make_odd(input logic [0:63] k);
      logic [0:63] r;
      r = k;
      for (int i = 0; i < 8; i++) r[8*i + 7] = ~(^r[8*i +: 7]);
      return r;
   endfunction

   task automatic push_run(input logic [0:63] k, input logic dec);
      exp_t e;
      for (int pos = 0; pos < 16; pos++) begin
         e.idx = 4'(pos);
         e.sk  = model_key(k, dec ? 16 - pos : pos + 1);
         sb.push_back(e);
      end
   endtask

   // Downstream ready: always, random, or a 5-cycle stall at position 3
   initial begin
      subkey_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: subkey_ready = 1'b1;
            1: subkey_ready = ($urandom % 4) != 0;
            default: begin
               if (subkey_valid && round_idx == 4'd3 && stall_cnt < 5) begin
                  subkey_ready = 1'b0;
                  stall_cnt++;
               end else subkey_ready = 1'b1;
            end
         endcase
      end
   end

   // Monitor: compare presented subkey with scoreboard head, pop on handshake
   always @(negedge clk) begin
      if (rst) begin
         done_due = 0;
         perr_due = 0;
      end else begin
         chk("subkey_valid", 64'(subkey_valid), 64'(sb.size() != 0));
         chk("busy", 64'(busy), 64'(sb.size() != 0));
         chk("done", 64'(done), 64'(done_due));
         chk("parity_err", 64'(parity_err), 64'(perr_due));
         done_due = 0;
         perr_due = 0;
         if (subkey_valid && sb.size() != 0) begin
            chk("round_idx", 64'(round_idx), 64'(sb[0].idx));
            chk("subkey", 64'(subkey), 64'(sb[0].sk));
            if (subkey_ready) begin
               got[round_idx] = subkey;
               if (sb[0].idx == 4'd15) done_due = 1;
               void'(sb.pop_front());
            end else stalled_obs++;
         end
      end
   end

   task automatic do_run(input logic [0:63] k, input logic dec, input int mode, input bit meddle);
      int cyc;
      ready_mode  = mode;
      stall_cnt   = 0;
      stalled_obs = 0;
      for (int i = 0; i < 16; i++) got[i] = '0;
      key     = k;
      decrypt = dec;
      start   = 1'b1;
      @(posedge clk);
      push_run(k, dec);
      #1;
      start   = 1'b0;
      key     = {$urandom, $urandom};
      decrypt = 1'($urandom);
      cyc = 0;
      while (sb.size() != 0 && cyc < 400) begin
         if (meddle) begin
            start   = (cyc >= 1 && cyc < 9);
            key     = OTHER_KEY;
            decrypt = ~dec;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      chk("run_complete", 64'(sb.size()), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      logic [0:63] rk;
      rst     = 1'b0;
      start   = 1'b0;
      decrypt = 1'b0;
      key     = '0;
      #1;
      rst = 1'b1;
      #1;
      chk("reset_valid", 64'(subkey_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_idx", 64'(round_idx), 64'd0);
      chk("reset_subkey", 64'(subkey), 64'd0);
      chk("reset_perr", 64'(parity_err), 64'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Known vector, both directions
      do_run(KNOWN_KEY, 1'b0, 0, 0);
      chk("enc_k1", 64'(got[0]), 64'(K1_KNOWN));
      chk("enc_k16", 64'(got[15]), 64'(K16_KNOWN));
      do_run(KNOWN_KEY, 1'b1, 0, 0);
      chk("dec_first", 64'(got[0]), 64'(K16_KNOWN));
      chk("dec_last", 64'(got[15]), 64'(K1_KNOWN));

      // Backpressure at position 3
      do_run(KNOWN_KEY, 1'b0, 2, 0);
      chk("stall_cycles", 64'(stalled_obs), 64'd5);

      // Start/key/decrypt wiggled mid-run
      do_run(KNOWN_KEY, 1'b0, 0, 1);
      chk("meddle_k16", 64'(got[15]), 64'(K16_KNOWN));

      // Asynchronous reset at position 7
      ready_mode = 0;
      key     = KNOWN_KEY;
      decrypt = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      push_run(KNOWN_KEY, 1'b0);
      #1;
      start = 1'b0;
      cyc = 0;
      while (round_idx != 4'd7 && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("reach_idx7", 64'(round_idx), 64'd7);
      #1;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("arst_valid", 64'(subkey_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_idx", 64'(round_idx), 64'd0);
      chk("arst_subkey", 64'(subkey), 64'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_run(KNOWN_KEY, 1'b0, 0, 0);
      chk("post_rst_k1", 64'(got[0]), 64'(K1_KNOWN));

`ifdef DES_KS_PARITY_CHECK_EN
      // All-zero key has even parity in every byte
      key     = '0;
      decrypt = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      perr_due = 1;
      #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      do_run(KNOWN_KEY, 1'b0, 0, 0);
      chk("par_ok_k1", 64'(got[0]), 64'(K1_KNOWN));
`endif

      // Random keys, directions and ready patterns
      for (int n = 0; n < 10; n++) begin
         rk = make_odd({$urandom, $urandom});
         do_run(rk, 1'($urandom), 1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
